// File: rtl/tcdm_sram_responder_pkg.sv
// ----------------------------------------------------------------------------
// tcdm_sram_responder_pkg
// Shared declarations for the TCDM scratchpad responder:
//   - tcdm_state_e           : grant FSM states (IDLE, STALL)
//   - TCDM_WEN_READ          : wen encoding that marks a read
//   - TCDM_ERR_RDATA_DEFAULT : data returned for an out-of-range read
//   - word_in_range()        : word-index bounds check against the bank depth
// ----------------------------------------------------------------------------
package tcdm_sram_responder_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      STALL = 1'b1
   } tcdm_state_e;

   localparam logic        TCDM_WEN_READ          = 1'b1;
   localparam logic [31:0] TCDM_ERR_RDATA_DEFAULT = 32'hBADACCE5;

   // True when a word index addresses a physically present scratchpad word.
   function automatic logic word_in_range(input logic [31:0] index,
                                          input logic [31:0] depth);
      return (index < depth);
   endfunction

endpackage

// File: rtl/tcdm_sram_bank.sv
// ----------------------------------------------------------------------------
// tcdm_sram_bank
// Single-port 32-bit storage array with per-byte write enables and a
// registered (synchronous) read port. The array itself is not reset; only the
// read-data register is.
// Ports:
//   asic_clk_i  clock
//   rst_n       asynchronous active-low reset (read register only)
//   en          access enable for this cycle
//   we          1 = write, 0 = read
//   addr        word address
//   wdata       write data
//   be          byte enables, be[n] covers wdata[8n+7:8n]
//   rdata       read data, updated on the edge of an enabled read, else held
// ----------------------------------------------------------------------------
module tcdm_sram_bank #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          asic_clk_i,
   input  logic          rst_n,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   input  logic [3:0]    be,
   output logic [31:0]   rdata
);

   logic [31:0] mem_r [DEPTH_WORDS];
   logic [31:0] rdata_r;

   // Byte-masked write into the array; contents survive reset.
   always_ff @(posedge asic_clk_i) begin
      if (en && we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
               mem_r[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
         end
      end
   end

   // Synchronous read register; holds between reads.
   always_ff @(posedge asic_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         rdata_r <= 32'd0;
      end else if (en && !we) begin
         rdata_r <= mem_r[addr];
      end else begin
         rdata_r <= rdata_r;
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/tcdm_sram_responder.sv
// ----------------------------------------------------------------------------
// tcdm_sram_responder
// Slave end of a TCDM port backed by a local word-addressed scratchpad.
// Single-word reads/writes with byte enables; the grant can be delayed by
// WAIT_CYCLES cycles of held request. Responses come one cycle after accept.
// Optional build macro: TCDM_SRAM_RESPONDER_ERR_EN adds the r_opc_o error
// response and a sticky out-of-range flag.
// Ports:
//   asic_clk_i  clock
//   rst_n       asynchronous active-low reset
//   req_i       request
//   add_i       byte address (bits [1:0] ignored)
//   wen_i       1 = read, 0 = write
//   wdata_i     write data
//   be_i        byte enables
//   gnt_o       grant (combinational from req_i and FSM state)
//   r_valid_o   one-cycle response strobe
//   r_rdata_o   read data, held between read responses
//   r_opc_o     error response (only with TCDM_SRAM_RESPONDER_ERR_EN)
// ----------------------------------------------------------------------------
module tcdm_sram_responder
   import tcdm_sram_responder_pkg::*;
#(
   parameter int          ADDR_WIDTH  = 20,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_CYCLES = 0,
   parameter logic [31:0] ERR_RDATA   = TCDM_ERR_RDATA_DEFAULT
) (
   input  logic                  asic_clk_i,
   input  logic                  rst_n,
   input  logic                  req_i,
   input  logic [ADDR_WIDTH-1:0] add_i,
   input  logic                  wen_i,
   input  logic [31:0]           wdata_i,
   input  logic [3:0]            be_i,
   output logic                  gnt_o,
   output logic                  r_valid_o,
   output logic [31:0]           r_rdata_o
`ifdef TCDM_SRAM_RESPONDER_ERR_EN
   ,
   output logic                  r_opc_o
`endif
);

   localparam int IDX_W   = ADDR_WIDTH - 2;
   localparam int BANK_AW = $clog2(DEPTH_WORDS);

   tcdm_state_e        state_r;
   logic [3:0]         cnt_r;
   logic               gnt_s;
   logic [IDX_W-1:0]   idx_s;
   logic               in_range_s;
   logic               accept_s;
   logic               is_read_s;
   logic               bank_en_s;
   logic [31:0]        bank_rdata_s;
   logic               r_valid_r;
   logic               rd_err_r;
   logic               unused_addr_s;

   assign idx_s         = add_i[ADDR_WIDTH-1:2];
   assign unused_addr_s = ^add_i[1:0];
   assign in_range_s    = word_in_range(32'(idx_s), 32'(DEPTH_WORDS));
   assign is_read_s     = (wen_i == TCDM_WEN_READ);
   assign accept_s      = req_i && gnt_s;
   // Out-of-range accesses never touch the array, so aliased low bits are safe.
   assign bank_en_s     = accept_s && in_range_s;

   // Grant decode: immediate in IDLE with no wait, else after the stall count.
   always_comb begin
      gnt_s = 1'b0;
      if (WAIT_CYCLES == 0) begin
         gnt_s = req_i && (state_r == IDLE);
      end else begin
         gnt_s = req_i && (state_r == STALL) && (cnt_r == 4'(WAIT_CYCLES));
      end
   end

   assign gnt_o = gnt_s;

   // Grant FSM: counts held-request cycles; a dropped request abandons the wait.
   always_ff @(posedge asic_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         cnt_r   <= 4'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (req_i && (WAIT_CYCLES != 0)) begin
                  state_r <= STALL;
                  cnt_r   <= 4'd1;
               end else begin
                  state_r <= IDLE;
                  cnt_r   <= 4'd0;
               end
            end
            STALL: begin
               if (!req_i || gnt_s) begin
                  state_r <= IDLE;
                  cnt_r   <= 4'd0;
               end else begin
                  state_r <= STALL;
                  cnt_r   <= cnt_r + 4'd1;
               end
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= 4'd0;
            end
         endcase
      end
   end

   tcdm_sram_bank #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (BANK_AW)
   ) u_bank (
      .asic_clk_i (asic_clk_i),
      .rst_n      (rst_n),
      .en         (bank_en_s),
      .we         (!is_read_s),
      .addr       (idx_s[BANK_AW-1:0]),
      .wdata      (wdata_i),
      .be         (be_i),
      .rdata      (bank_rdata_s)
   );

   // Response pipeline; rd_err_r selects ERR_RDATA and only changes on reads,
   // so writes leave the visible read data untouched.
   always_ff @(posedge asic_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         r_valid_r <= 1'b0;
         rd_err_r  <= 1'b0;
      end else begin
         r_valid_r <= accept_s;
         if (accept_s && is_read_s) begin
            rd_err_r <= !in_range_s;
         end else begin
            rd_err_r <= rd_err_r;
         end
      end
   end

   assign r_valid_o = r_valid_r;
   assign r_rdata_o = rd_err_r ? ERR_RDATA : bank_rdata_s;

`ifdef TCDM_SRAM_RESPONDER_ERR_EN
   logic r_opc_r;
   logic err_seen_r;

   // Error response travels with r_valid; sticky flag records any bad access.
   always_ff @(posedge asic_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         r_opc_r    <= 1'b0;
         err_seen_r <= 1'b0;
      end else begin
         r_opc_r <= accept_s && !in_range_s;
         if (accept_s && !in_range_s) begin
            err_seen_r <= 1'b1;
         end else begin
            err_seen_r <= err_seen_r;
         end
      end
   end

   assign r_opc_o = r_opc_r;

`ifndef SYNTHESIS
   // Report the first out-of-range access since reset.
   always_ff @(posedge asic_clk_i) begin
      if (rst_n && accept_s && !in_range_s && !err_seen_r) begin
         $error("tcdm_sram_responder: out-of-range access, index 0x%0h", idx_s);
      end
   end
`endif
`endif

endmodule

// File: tb/tb_tcdm_sram_responder.sv
// ----------------------------------------------------------------------------
// tb_tcdm_sram_responder
// Directed bench for tcdm_sram_responder. Two instances share the bus inputs
// except req: u_dut0 (WAIT_CYCLES=0) and u_dut3 (WAIT_CYCLES=3). Inputs change
// on the falling edge; gnt is sampled 1 ns after that, registered outputs
// 1 ns after the rising edge.
// ----------------------------------------------------------------------------
module tb_tcdm_sram_responder;

   logic        clk;
   logic        rst_n;
   logic        req0, req3;
   logic [19:0] add;
   logic        wen;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic        gnt0, rv0, gnt3, rv3;
   logic [31:0] rd0, rd3;
`ifdef TCDM_SRAM_RESPONDER_ERR_EN
   logic        opc0, opc3;
`endif

   int checks   = 0;
   int failures = 0;

   tcdm_sram_responder #(.WAIT_CYCLES(0)) u_dut0 (
      .asic_clk_i (clk),   .rst_n (rst_n),   .req_i (req0),
      .add_i      (add),   .wen_i (wen),     .wdata_i (wdata),
      .be_i       (be),    .gnt_o (gnt0),    .r_valid_o (rv0),
      .r_rdata_o  (rd0)
`ifdef TCDM_SRAM_RESPONDER_ERR_EN
      , .r_opc_o  (opc0)
`endif
   );

   tcdm_sram_responder #(.WAIT_CYCLES(3)) u_dut3 (
      .asic_clk_i (clk),   .rst_n (rst_n),   .req_i (req3),
      .add_i      (add),   .wen_i (wen),     .wdata_i (wdata),
      .be_i       (be),    .gnt_o (gnt3),    .r_valid_o (rv3),
      .r_rdata_o  (rd3)
`ifdef TCDM_SRAM_RESPONDER_ERR_EN
      , .r_opc_o  (opc3)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drv(input logic r0, input logic r3, input logic [19:0] a,
                      input logic w, input logic [31:0] d, input logic [3:0] b);
      @(negedge clk);
      req0 = r0; req3 = r3; add = a; wen = w; wdata = d; be = b;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; req0 = 1'b0; req3 = 1'b0; add = 20'h0; wen = 1'b1;
      wdata = 32'h0; be = 4'h0;
      repeat (2) @(negedge clk);
      // Reset state
      chk("rst_gnt0",  {31'd0, gnt0}, 32'd0);
      chk("rst_rv0",   {31'd0, rv0},  32'd0);
      chk("rst_rd0",   rd0,           32'd0);
      chk("rst_rv3",   {31'd0, rv3},  32'd0);
      chk("rst_rd3",   rd3,           32'd0);
      rst_n = 1'b1;

      // Zero-wait write then read of 0x10
      drv(1'b1, 1'b0, 20'h00010, 1'b0, 32'hDEADBEEF, 4'hF);
      chk("w10_gnt", {31'd0, gnt0}, 32'd1);
      tick();
      chk("w10_rv",  {31'd0, rv0}, 32'd1);
      drv(1'b1, 1'b0, 20'h00010, 1'b1, 32'h0, 4'hF);
      chk("r10_gnt", {31'd0, gnt0}, 32'd1);
      tick();
      chk("r10_rv",  {31'd0, rv0}, 32'd1);
      chk("r10_rd",  rd0, 32'hDEADBEEF);
      drv(1'b0, 1'b0, 20'h00010, 1'b1, 32'h0, 4'hF);
      chk("idle_gnt", {31'd0, gnt0}, 32'd0);
      tick();
      chk("idle_rv",   {31'd0, rv0}, 32'd0);
      chk("idle_hold", rd0, 32'hDEADBEEF);

      // Byte enables, back-to-back read after write
      drv(1'b1, 1'b0, 20'h00020, 1'b0, 32'h11223344, 4'hF);
      tick();
      drv(1'b1, 1'b0, 20'h00020, 1'b0, 32'hAABBCCDD, 4'b0101);
      tick();
      chk("be_wr_rv", {31'd0, rv0}, 32'd1);
      drv(1'b1, 1'b0, 20'h00020, 1'b1, 32'h0, 4'hF);
      tick();
      chk("be_rd", rd0, 32'h11BB33DD);

      // Out-of-range: 0x1000 is word 1024, aliases word 0 in the low bits
      drv(1'b1, 1'b0, 20'h00000, 1'b0, 32'h12345678, 4'hF);
      tick();
      drv(1'b1, 1'b0, 20'h01000, 1'b0, 32'h00000005, 4'hF);
      chk("oorw_gnt", {31'd0, gnt0}, 32'd1);
      tick();
      chk("oorw_rv", {31'd0, rv0}, 32'd1);
`ifdef TCDM_SRAM_RESPONDER_ERR_EN
      chk("oorw_opc", {31'd0, opc0}, 32'd1);
`endif
      drv(1'b1, 1'b0, 20'h01000, 1'b1, 32'h0, 4'hF);
      tick();
      chk("oorr_rv", {31'd0, rv0}, 32'd1);
      chk("oorr_rd", rd0, 32'hBADACCE5);
`ifdef TCDM_SRAM_RESPONDER_ERR_EN
      chk("oorr_opc", {31'd0, opc0}, 32'd1);
`endif
      drv(1'b1, 1'b0, 20'h00000, 1'b1, 32'h0, 4'hF);
      tick();
      chk("w0_intact", rd0, 32'h12345678);
`ifdef TCDM_SRAM_RESPONDER_ERR_EN
      chk("w0_opc", {31'd0, opc0}, 32'd0);
`endif
      // be=0 write: response given, data and visible rdata unchanged
      drv(1'b1, 1'b0, 20'h00000, 1'b0, 32'hFFFFFFFF, 4'h0);
      tick();
      chk("be0_rv",   {31'd0, rv0}, 32'd1);
      chk("be0_hold", rd0, 32'h12345678);
      drv(1'b1, 1'b0, 20'h00000, 1'b1, 32'h0, 4'hF);
      tick();
      chk("be0_rd", rd0, 32'h12345678);

      // Streaming: preload 8 words then 8 back-to-back reads with req held
      for (int i = 0; i < 8; i++) begin
         drv(1'b1, 1'b0, 20'(32'h40 + 4 * i), 1'b0, 32'hC0DE0000 + 32'(i), 4'hF);
         tick();
      end
      for (int i = 0; i < 8; i++) begin
         drv(1'b1, 1'b0, 20'(32'h40 + 4 * i), 1'b1, 32'h0, 4'hF);
         chk("str_gnt", {31'd0, gnt0}, 32'd1);
         tick();
         chk("str_rv", {31'd0, rv0}, 32'd1);
         chk("str_rd", rd0, 32'hC0DE0000 + 32'(i));
      end
      drv(1'b0, 1'b0, 20'h0, 1'b1, 32'h0, 4'hF);
      tick();
      chk("str_end_rv", {31'd0, rv0}, 32'd0);

      // WAIT_CYCLES=3: grant on the 4th held cycle
      for (int c = 1; c <= 4; c++) begin
         drv(1'b0, 1'b1, 20'h00010, 1'b0, 32'hA5A5A5A5, 4'hF);
         chk("w3_gnt", {31'd0, gnt3}, (c == 4) ? 32'd1 : 32'd0);
         tick();
         chk("w3_rv", {31'd0, rv3}, (c == 4) ? 32'd1 : 32'd0);
      end
      // Abort after 2 cycles: no grant, no response
      for (int c = 1; c <= 2; c++) begin
         drv(1'b0, 1'b1, 20'h00010, 1'b1, 32'h0, 4'hF);
         chk("ab_gnt", {31'd0, gnt3}, 32'd0);
         tick();
         chk("ab_rv", {31'd0, rv3}, 32'd0);
      end
      drv(1'b0, 1'b0, 20'h00010, 1'b1, 32'h0, 4'hF);
      chk("ab_drop_gnt", {31'd0, gnt3}, 32'd0);
      tick();
      chk("ab_drop_rv", {31'd0, rv3}, 32'd0);
      // Fresh request must again wait the full count (FSM and counter idle)
      for (int c = 1; c <= 4; c++) begin
         drv(1'b0, 1'b1, 20'h00010, 1'b1, 32'h0, 4'hF);
         chk("r3_gnt", {31'd0, gnt3}, (c == 4) ? 32'd1 : 32'd0);
         tick();
         chk("r3_rv", {31'd0, rv3}, (c == 4) ? 32'd1 : 32'd0);
      end
      chk("r3_rd", rd3, 32'hA5A5A5A5);
      drv(1'b0, 1'b0, 20'h0, 1'b1, 32'h0, 4'hF);
      tick();

      // Reset in the response cycle of a read
      drv(1'b1, 1'b0, 20'h00020, 1'b1, 32'h0, 4'hF);
      tick();
      chk("pre_rst_rv", {31'd0, rv0}, 32'd1);
      chk("pre_rst_rd", rd0, 32'h11BB33DD);
      rst_n = 1'b0;
      req0  = 1'b0;
      #1;
      chk("mid_rst_rv", {31'd0, rv0}, 32'd0);
      chk("mid_rst_rd", rd0, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("post_rst_rv1", {31'd0, rv0}, 32'd0);
      tick();
      chk("post_rst_rv2", {31'd0, rv0}, 32'd0);
      drv(1'b1, 1'b0, 20'h00020, 1'b1, 32'h0, 4'hF);
      tick();
      chk("post_rst_rd", rd0, 32'h11BB33DD);
      drv(1'b1, 1'b0, 20'h0005C, 1'b1, 32'h0, 4'hF);
      tick();
      chk("post_rst_rd2", rd0, 32'hC0DE0007);
      drv(1'b0, 1'b0, 20'h0, 1'b1, 32'h0, 4'hF);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
